// File: rtl/sipo_if.sv
// Serial-in / parallel-out handshake bundle for sipo_deserializer.
// slave is the deserializer side; master is the bit source / word sink side.
interface sipo_if #(
  parameter int W = 4
);
  localparam int CW = $clog2(W);

  logic          sin;
  logic          sin_valid;
  logic          sin_ready;
  logic          frame_clr;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [CW-1:0] bit_cnt;
  logic          frame_err;

  modport master (
    output sin, sin_valid, frame_clr, dout_ready,
    input  sin_ready, dout, dout_valid, bit_cnt, frame_err
  );

  modport slave (
    input  sin, sin_valid, frame_clr, dout_ready,
    output sin_ready, dout, dout_valid, bit_cnt, frame_err
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Collects a serial bit stream into W-bit words and presents them on a
// valid/ready output, with input backpressure, resync and a sticky framing error.
//
// state   | meaning
// COLLECT | accepting bits into sr; completed words go straight to dout if free
// STALL   | a completed word waits in sr behind an unconsumed dout; sin blocked
module sipo_deserializer #(
  parameter int W         = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   clk,
  input  logic   reset,
  sipo_if.slave  bus
);
  localparam int CW = $clog2(W);

  typedef enum logic {COLLECT, STALL} state_t;

  state_t        state_q, state_n;
  logic [W-1:0]  sr_q, sr_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [W-1:0]  dout_q, dout_n;
  logic          dv_q, dv_n;
  logic          err_q, err_n;
  logic [W-1:0]  shifted;
  logic          consume;

  assign bus.sin_ready  = (state_q == COLLECT);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.frame_err  = err_q;

  assign consume = dv_q && bus.dout_ready;

  always_comb begin
    if (MSB_FIRST) shifted = {sr_q[W-2:0], bus.sin};
    else           shifted = {bus.sin, sr_q[W-1:1]};
  end

  always_comb begin
    state_n = state_q;
    sr_n    = sr_q;
    cnt_n   = cnt_q;
    dout_n  = dout_q;
    dv_n    = dv_q;
    err_n   = err_q;

    // a plain consume frees dout; any load below re-asserts valid
    if (consume) dv_n = 1'b0;

    if (bus.frame_clr) begin
      sr_n    = '0;
      cnt_n   = '0;
      state_n = COLLECT;
      if (cnt_q != '0 || state_q == STALL) err_n = 1'b1;
    end else begin
      case (state_q)
        COLLECT: begin
          if (bus.sin_valid) begin
            sr_n = shifted;
            if (cnt_q == CW'(W - 1)) begin
              cnt_n = '0;
              if (!dv_q || bus.dout_ready) begin
                dout_n = shifted;
                dv_n   = 1'b1;
              end else begin
                state_n = STALL;
              end
            end else begin
              cnt_n = cnt_q + CW'(1);
            end
          end
        end
        STALL: begin
          if (consume) begin
            dout_n  = sr_q;
            dv_n    = 1'b1;
            sr_n    = '0;
            state_n = COLLECT;
          end
        end
        default: state_n = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= COLLECT;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      sr_q    <= sr_n;
      cnt_q   <= cnt_n;
      dout_q  <= dout_n;
      dv_q    <= dv_n;
      err_q   <= err_n;
    end
  end
endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: drives one bit stream into an MSB-first and an LSB-first
// deserializer and checks every transferred word plus handshake/flag state.
module tb_sipo_deserializer;
  logic clk = 1'b0;
  logic reset;
  logic sin, sin_valid, frame_clr, dout_ready;

  int checks = 0;
  int errors = 0;

  logic [3:0] q1[$];
  logic [3:0] q0[$];

  sipo_if #(.W(4)) i1 ();
  sipo_if #(.W(4)) i0 ();

  assign i1.sin = sin;  assign i1.sin_valid = sin_valid;
  assign i1.frame_clr = frame_clr;  assign i1.dout_ready = dout_ready;
  assign i0.sin = sin;  assign i0.sin_valid = sin_valid;
  assign i0.frame_clr = frame_clr;  assign i0.dout_ready = dout_ready;

  sipo_deserializer #(.W(4), .MSB_FIRST(1'b1)) dut_msb (.clk(clk), .reset(reset), .bus(i1));
  sipo_deserializer #(.W(4), .MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .reset(reset), .bus(i0));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] e1, input logic [3:0] e0);
    q1.push_back(e1);
    q0.push_back(e0);
  endtask

  task automatic bit_in(input logic b);
    sin = b;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  task automatic check_both(input string name, input logic a1, input logic a0, input logic e);
    check({name, "_msb"}, 32'(a1), 32'(e));
    check({name, "_lsb"}, 32'(a0), 32'(e));
  endtask

  // monitor: every completed transfer must match the next expected word
  always @(negedge clk) begin
    if (reset === 1'b1 && i1.dout_valid && dout_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL msb_word unexpected actual=%0h expected=none", i1.dout);
      end else check("msb_word", 32'(i1.dout), 32'(q1.pop_front()));
    end
    if (reset === 1'b1 && i0.dout_valid && dout_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL lsb_word unexpected actual=%0h expected=none", i0.dout);
      end else check("lsb_word", 32'(i0.dout), 32'(q0.pop_front()));
    end
  end

  initial begin
    reset = 1'b0; sin = 1'b0; sin_valid = 1'b0; frame_clr = 1'b0; dout_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    check("rst_dout_msb", 32'(i1.dout), 32'h0);
    check("rst_dout_lsb", 32'(i0.dout), 32'h0);
    check_both("rst_dv", i1.dout_valid, i0.dout_valid, 1'b0);
    check("rst_cnt", 32'(i1.bit_cnt), 32'h0);
    check_both("rst_err", i1.frame_err, i0.frame_err, 1'b0);
    check_both("rst_rdy", i1.sin_ready, i0.sin_ready, 1'b1);
    tick();

    // single word, then one-cycle valid pulse
    push(4'b1011, 4'b1101);
    bit_in(1); bit_in(0); bit_in(1);
    check("cnt3", 32'(i1.bit_cnt), 32'h3);
    bit_in(1);
    check_both("w1_dv", i1.dout_valid, i0.dout_valid, 1'b1);
    check("w1_cnt", 32'(i1.bit_cnt), 32'h0);
    tick();
    check_both("w1_dv_drop", i1.dout_valid, i0.dout_valid, 1'b0);

    // eight back-to-back bits, two words
    push(4'b1011, 4'b1101);
    push(4'b0110, 4'b0110);
    foreach (q1[k]) begin end
    begin
      logic [7:0] s = 8'b1011_0110;
      for (int i = 7; i >= 0; i--) begin
        check_both("b2b_rdy", i1.sin_ready, i0.sin_ready, 1'b1);
        bit_in(s[i]);
        if (i == 4 || i == 0) check_both("b2b_dv", i1.dout_valid, i0.dout_valid, 1'b1);
        if (i == 2) check_both("b2b_gap", i1.dout_valid, i0.dout_valid, 1'b0);
      end
    end
    tick();

    // sin_valid gaps with junk on sin between accepted bits
    push(4'b1011, 4'b1101);
    begin
      logic [3:0] s = 4'b1011;
      for (int i = 3; i >= 0; i--) begin
        bit_in(s[i]);
        if (i != 0) begin
          sin = ~s[i];
          tick();
        end
      end
    end
    check_both("gap_dv", i1.dout_valid, i0.dout_valid, 1'b1);
    tick();

    // backpressure into STALL
    dout_ready = 1'b0;
    push(4'b1011, 4'b1101);
    push(4'b0110, 4'b0110);
    begin
      logic [7:0] s = 8'b1011_0110;
      for (int i = 7; i >= 0; i--) bit_in(s[i]);
    end
    check_both("stall_rdy", i1.sin_ready, i0.sin_ready, 1'b0);
    check("stall_hold_msb", 32'(i1.dout), 32'hB);
    check("stall_hold_lsb", 32'(i0.dout), 32'hD);
    bit_in(1); bit_in(1);
    check("stall_cnt", 32'(i1.bit_cnt), 32'h0);
    check("stall_hold2_msb", 32'(i1.dout), 32'hB);
    dout_ready = 1'b1;
    tick();
    check_both("unstall_rdy", i1.sin_ready, i0.sin_ready, 1'b1);
    check_both("unstall_dv", i1.dout_valid, i0.dout_valid, 1'b1);
    check("unstall_dout", 32'(i1.dout), 32'h6);
    tick();
    check_both("unstall_drain", i1.dout_valid, i0.dout_valid, 1'b0);

    // frame_clr mid-word, then clean word, then harmless frame_clr
    bit_in(1); bit_in(1);
    frame_clr = 1'b1; sin = 1'b1; sin_valid = 1'b1;
    tick();
    frame_clr = 1'b0; sin_valid = 1'b0;
    check("fc_cnt", 32'(i1.bit_cnt), 32'h0);
    check_both("fc_err", i1.frame_err, i0.frame_err, 1'b1);
    push(4'b0011, 4'b1100);
    bit_in(0); bit_in(0); bit_in(1); bit_in(1);
    check_both("fc_word_dv", i1.dout_valid, i0.dout_valid, 1'b1);
    tick();
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    check_both("fc2_err", i1.frame_err, i0.frame_err, 1'b1);
    check_both("fc2_dv", i1.dout_valid, i0.dout_valid, 1'b0);
    check("fc2_dout_msb", 32'(i1.dout), 32'h3);
    check("fc2_dout_lsb", 32'(i0.dout), 32'hC);

    // reset while stalled
    dout_ready = 1'b0;
    begin
      logic [7:0] s = 8'b1011_0110;
      for (int i = 7; i >= 0; i--) bit_in(s[i]);
    end
    check_both("pre_rst_rdy", i1.sin_ready, i0.sin_ready, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_both("srst_dv", i1.dout_valid, i0.dout_valid, 1'b0);
    check("srst_dout", 32'(i1.dout), 32'h0);
    check("srst_cnt", 32'(i1.bit_cnt), 32'h0);
    check_both("srst_rdy", i1.sin_ready, i0.sin_ready, 1'b1);
    check_both("srst_err", i1.frame_err, i0.frame_err, 1'b0);
    tick();

    check("leftover_msb", 32'(q1.size()), 32'h0);
    check("leftover_lsb", 32'(q0.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
